// File: rtl/mainvga_ctrl.sv
`default_nettype none
// ============================================================================
// mainvga_ctrl : switch-triggered 160x120 framebuffer fill + 640x480 scan-out
// Rev 1.0
// ============================================================================
module mainvga_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  SW,
  input  logic [31:0] trigger,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_CLK,
  output logic [7:0]  VGA_X,
  output logic [6:0]  VGA_Y,
  output logic [2:0]  VGA_COLOUR,
  output logic        VGA_PLOT
);

  localparam logic [7:0] X_LAST       = 8'd159;
  localparam logic [6:0] Y_LAST       = 7'd119;
  localparam logic [7:0] X_SPLIT      = 8'd80;
  localparam logic [6:0] Y_SPLIT      = 7'd60;
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;
  localparam logic [9:0] V_LAST       = 10'd524;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Switch index 0 = SW[8] (clear), index 1 = SW[9] (status)
  logic [1:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [1:0] sw_prev_q, sw_prev_d, sw_rise_q, sw_rise_d;

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic       mode_clear_q, mode_clear_d;
  logic [3:0] trig_q, trig_d;

  logic       vga_clk_q, vga_clk_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       vis_p1_q, vis_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
  logic       hs_q, hs_d, vs_q, vs_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic        fill_active, pix_en, visible;
  logic [1:0]  quad;
  logic [2:0]  colour_px, fb_rd_q;
  logic [14:0] wr_addr, rd_addr;
  logic [2:0]  fb_mem [0:19199];
  logic        unused_inputs;

  assign unused_inputs = ^{SW[7:0], trigger[31:4]};

  always_comb begin
    sw_meta_d = SW[9:8];
    sw_sync_d = sw_meta_q;
    sw_prev_d = sw_sync_q;
    sw_rise_d = sw_sync_q & ~sw_prev_q;
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    mode_clear_d = mode_clear_q;
    trig_d       = trig_q;
    case (state_q)
      ST_IDLE: begin
        if (|sw_rise_q) begin
          state_d      = ST_FILL;
          mode_clear_d = sw_rise_q[0];
          trig_d       = trigger[3:0];
          x_d          = 8'd0;
          y_d          = 7'd0;
        end
      end
      ST_FILL: begin
        if (x_q == X_LAST) begin
          x_d = 8'd0;
          if (y_q == Y_LAST) begin
            y_d     = 7'd0;
            state_d = ST_DONE;
          end else begin
            y_d = y_q + 7'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      ST_DONE: begin
        if (sw_sync_q == 2'b00) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fill_active = (state_q == ST_FILL);
  assign quad        = {y_q >= Y_SPLIT, x_q >= X_SPLIT};
  assign colour_px   = mode_clear_q ? 3'b000 : (trig_q[quad] ? 3'b100 : 3'b010);

  assign VGA_PLOT   = fill_active;
  assign VGA_X      = fill_active ? x_q : 8'd0;
  assign VGA_Y      = fill_active ? y_q : 7'd0;
  assign VGA_COLOUR = fill_active ? colour_px : 3'b000;

  assign pix_en  = vga_clk_q;
  assign visible = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
  assign wr_addr = 15'(y_q) * 15'd160 + 15'(x_q);
  assign rd_addr = visible ? (15'(v_q[8:2]) * 15'd160 + 15'(h_q[9:2])) : 15'd0;

  // Sync and visibility travel through the same two pixel stages as the RAM
  // read so colour, HS and VS leave the block aligned.
  always_comb begin
    vga_clk_d = ~vga_clk_q;
    h_d       = h_q;
    v_d       = v_q;
    vis_p1_d  = vis_p1_q;
    hs_p1_d   = hs_p1_q;
    vs_p1_d   = vs_p1_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      vis_p1_d = visible;
      hs_p1_d  = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
      vs_p1_d  = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
      hs_d     = hs_p1_q;
      vs_d     = vs_p1_q;
      r_d      = (vis_p1_q && fb_rd_q[2]) ? 8'hFF : 8'h00;
      g_d      = (vis_p1_q && fb_rd_q[1]) ? 8'hFF : 8'h00;
      b_d      = (vis_p1_q && fb_rd_q[0]) ? 8'hFF : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q    <= 2'b00;
      sw_sync_q    <= 2'b00;
      sw_prev_q    <= 2'b00;
      sw_rise_q    <= 2'b00;
      state_q      <= ST_IDLE;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      mode_clear_q <= 1'b0;
      trig_q       <= 4'd0;
      vga_clk_q    <= 1'b0;
      h_q          <= 10'd0;
      v_q          <= 10'd0;
      vis_p1_q     <= 1'b0;
      hs_p1_q      <= 1'b1;
      vs_p1_q      <= 1'b1;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      r_q          <= 8'd0;
      g_q          <= 8'd0;
      b_q          <= 8'd0;
    end else begin
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      sw_prev_q    <= sw_prev_d;
      sw_rise_q    <= sw_rise_d;
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      mode_clear_q <= mode_clear_d;
      trig_q       <= trig_d;
      vga_clk_q    <= vga_clk_d;
      h_q          <= h_d;
      v_q          <= v_d;
      vis_p1_q     <= vis_p1_d;
      hs_p1_q      <= hs_p1_d;
      vs_p1_q      <= vs_p1_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
    end
  end

  // Framebuffer RAM: contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (fill_active) fb_mem[wr_addr] <= colour_px;
    if (pix_en)      fb_rd_q <= fb_mem[rd_addr];
  end

  assign VGA_CLK = vga_clk_q;
  assign VGA_HS  = hs_q;
  assign VGA_VS  = vs_q;
  assign VGA_R   = r_q;
  assign VGA_G   = g_q;
  assign VGA_B   = b_q;

endmodule
`default_nettype wire

// File: tb/tb_mainvga_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mainvga_ctrl : randomized self-checking bench for mainvga_ctrl
// Rev 1.0
// ============================================================================
module tb_mainvga_ctrl;

  logic        clk;
  logic        rst_n;
  logic [9:0]  SW;
  logic [31:0] trigger;
  logic [7:0]  VGA_R, VGA_G, VGA_B, VGA_X;
  logic        VGA_HS, VGA_VS, VGA_CLK, VGA_PLOT;
  logic [6:0]  VGA_Y;
  logic [2:0]  VGA_COLOUR;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  obs_x [19200];
  logic [6:0]  obs_y [19200];
  logic [2:0]  obs_c [19200];
  int          obs_n, obs_lat;
  logic [18:0] obs_post;

  mainvga_ctrl dut (
    .clk(clk), .rst_n(rst_n), .SW(SW), .trigger(trigger),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_CLK(VGA_CLK),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOUR(VGA_COLOUR), .VGA_PLOT(VGA_PLOT)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference picture: quadrant index from the pixel position, colour from the captured flags.
  function automatic logic [2:0] ref_colour(input bit clear, input logic [3:0] trig,
                                            input int x, input int y);
    int q;
    q = (x >= 80 ? 1 : 0) + (y >= 60 ? 2 : 0);
    if (clear) return 3'b000;
    return trig[q] ? 3'b100 : 3'b010;
  endfunction

  // Records one fill as seen on the plot port; called right after a switch is raised at a negedge.
  task automatic collect_fill();
    obs_lat = 0;
    while (VGA_PLOT !== 1'b1 && obs_lat < 100) begin
      @(negedge clk);
      obs_lat++;
    end
    obs_n = 0;
    while (VGA_PLOT === 1'b1 && obs_n < 19300) begin
      if (obs_n < 19200) begin
        obs_x[obs_n] = VGA_X;
        obs_y[obs_n] = VGA_Y;
        obs_c[obs_n] = VGA_COLOUR;
      end
      obs_n++;
      @(negedge clk);
    end
    obs_post = {VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR};
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    SW      = 10'($urandom());
    trigger = $urandom();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR, VGA_HS, VGA_VS, VGA_CLK, VGA_R, VGA_G, VGA_B}
        !== {19'd0, 1'b1, 1'b1, 1'b0, 24'd0})
      $display("FAIL reset_outputs: plot=%b x=%0d y=%0d col=%b hs=%b vs=%b vclk=%b rgb=%h%h%h expected plot=0 xyc=0 hs=vs=1 vclk=0 rgb=0",
               VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR, VGA_HS, VGA_VS, VGA_CLK, VGA_R, VGA_G, VGA_B);
    if ({VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR, VGA_HS, VGA_VS, VGA_CLK, VGA_R, VGA_G, VGA_B}
        !== {19'd0, 1'b1, 1'b1, 1'b0, 24'd0}) n_fail++;
    SW = 10'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    SW      = {2'b00, 8'($urandom())};
    trigger = 32'h8;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n_checks++;
      if ({VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR} !== 19'd0) begin
        n_fail++;
        $display("FAIL idle_quiet cycle %0d: plot=%b x=%0d y=%0d col=%b expected all 0",
                 i, VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR);
      end
    end
  endtask

  task automatic test_status_fill();
    logic [3:0] trig;
    trigger = ($urandom() & 32'hFFFF_FFF0) | 32'h8;
    trig    = 4'h8;
    SW[9]   = 1'b1;
    fork
      collect_fill();
      begin
        repeat (250) @(negedge clk);
        SW[9] = 1'b0;
        repeat (100) @(negedge clk);
        SW[8] = 1'b1;
      end
    join
    n_checks++;
    if (obs_lat - 1 !== 3) begin
      n_fail++;
      $display("FAIL status_latency: got %0d edges expected 3", obs_lat - 1);
    end
    n_checks++;
    if (obs_n !== 19200) begin
      n_fail++;
      $display("FAIL status_count: got %0d plots expected 19200", obs_n);
    end
    for (int k = 0; k < 19200; k++) begin
      n_checks++;
      if ({obs_x[k], obs_y[k], obs_c[k]} !== {8'(k % 160), 7'(k / 160), ref_colour(1'b0, trig, k % 160, k / 160)}) begin
        n_fail++;
        $display("FAIL status_pixel %0d: got (%0d,%0d,%b) expected (%0d,%0d,%b)", k, obs_x[k], obs_y[k],
                 obs_c[k], k % 160, k / 160, ref_colour(1'b0, trig, k % 160, k / 160));
      end
    end
    n_checks++;
    if ({obs_c[0], obs_c[60*160+80], obs_c[19199], obs_c[59*160+79]} !== {3'b010, 3'b100, 3'b100, 3'b010}) begin
      n_fail++;
      $display("FAIL status_corners: got %b %b %b %b expected 010 100 100 010",
               obs_c[0], obs_c[60*160+80], obs_c[19199], obs_c[59*160+79]);
    end
    n_checks++;
    if (obs_post !== 19'd0) begin
      n_fail++;
      $display("FAIL status_done_outputs: got %h expected 0", obs_post);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (VGA_PLOT !== 1'b0) begin
        n_fail++;
        $display("FAIL done_hold cycle %0d: plot=%b expected 0", i, VGA_PLOT);
      end
    end
  endtask

  task automatic test_clear_after_done();
    SW[8] = 1'b0;
    repeat (10) @(negedge clk);
    trigger = $urandom();
    SW[8]   = 1'b1;
    collect_fill();
    n_checks++;
    if (obs_lat - 1 !== 3) begin
      n_fail++;
      $display("FAIL clear_latency: got %0d edges expected 3", obs_lat - 1);
    end
    n_checks++;
    if (obs_n !== 19200) begin
      n_fail++;
      $display("FAIL clear_count: got %0d plots expected 19200", obs_n);
    end
    for (int k = 0; k < 19200; k++) begin
      n_checks++;
      if ({obs_x[k], obs_y[k], obs_c[k]} !== {8'(k % 160), 7'(k / 160), 3'b000}) begin
        n_fail++;
        $display("FAIL clear_pixel %0d: got (%0d,%0d,%b) expected (%0d,%0d,000)",
                 k, obs_x[k], obs_y[k], obs_c[k], k % 160, k / 160);
      end
    end
    SW = 10'd0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_same_cycle();
    int lat;
    trigger = $urandom();
    SW[9:8] = 2'b11;
    lat = 0;
    while (VGA_PLOT !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat - 1 !== 3) begin
      n_fail++;
      $display("FAIL both_latency: got %0d edges expected 3", lat - 1);
    end
    for (int k = 0; k < 3000; k++) begin
      n_checks++;
      if ({VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR} !== {1'b1, 8'(k % 160), 7'(k / 160), 3'b000}) begin
        n_fail++;
        $display("FAIL both_pixel %0d: got plot=%b (%0d,%0d,%b) expected plot=1 (%0d,%0d,000)",
                 k, VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR, k % 160, k / 160);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [3:0] trig;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR} !== 19'd0) begin
      n_fail++;
      $display("FAIL abort_async: plot=%b x=%0d y=%0d col=%b expected all 0",
               VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR);
    end
    SW = 10'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n_checks++;
      if (VGA_PLOT !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet cycle %0d: plot=%b expected 0", i, VGA_PLOT);
      end
    end
    trigger = ($urandom() & 32'hFFFF_FFF0) | 32'h1;
    trig    = 4'h1;
    SW[9]   = 1'b1;
    collect_fill();
    n_checks++;
    if (obs_n !== 19200) begin
      n_fail++;
      $display("FAIL refill_count: got %0d plots expected 19200", obs_n);
    end
    for (int k = 0; k < 19200; k++) begin
      n_checks++;
      if ({obs_x[k], obs_y[k], obs_c[k]} !== {8'(k % 160), 7'(k / 160), ref_colour(1'b0, trig, k % 160, k / 160)}) begin
        n_fail++;
        $display("FAIL refill_pixel %0d: got (%0d,%0d,%b) expected (%0d,%0d,%b)", k, obs_x[k], obs_y[k],
                 obs_c[k], k % 160, k / 160, ref_colour(1'b0, trig, k % 160, k / 160));
      end
    end
  endtask

  // After a reset the raster restarts at line 0 while the picture stays in memory.
  // c counts negedges from the first HS low sample (h=656 of line 0); line 1 pixel h shows at c=288+2h.
  task automatic test_video();
    int   w, h;
    logic prev_vclk;
    logic [23:0] exp_rgb;
    SW = 10'd0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    while (VGA_HS !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (w >= 3000) begin
      n_fail++;
      $display("FAIL hs_first_fall: no HS low within %0d cycles", w);
    end
    prev_vclk = VGA_CLK;
    for (int c = 0; c < 1888; c++) begin
      if (c > 0) begin
        @(negedge clk);
        n_checks++;
        if (VGA_CLK === prev_vclk) begin
          n_fail++;
          $display("FAIL vga_clk_toggle c=%0d: stayed %b", c, VGA_CLK);
        end
      end
      prev_vclk = VGA_CLK;
      n_checks++;
      if ({VGA_HS, VGA_VS} !== {((c % 1600) >= 192) ? 1'b1 : 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL sync c=%0d: hs=%b vs=%b expected hs=%b vs=1", c, VGA_HS, VGA_VS, (c % 1600) >= 192);
      end
      h = (c - 288) / 2;
      exp_rgb = 24'd0;
      if (c >= 288 && h < 320)             exp_rgb = 24'hFF0000;
      else if (c >= 288 && h < 640)        exp_rgb = 24'h00FF00;
      n_checks++;
      if ({VGA_R, VGA_G, VGA_B} !== exp_rgb) begin
        n_fail++;
        $display("FAIL line_rgb c=%0d: got %h expected %h", c, {VGA_R, VGA_G, VGA_B}, exp_rgb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_status_fill();
    test_clear_after_done();
    test_same_cycle();
    test_reset_mid_fill();
    test_video();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
